// File: rtl/sdp_sync_fifo_v2.sv
// sdp_sync_fifo_v2
// Single-clock FIFO on an internal simple-dual-port RAM.
//   FWFT=0 : standard read, fifo_rdat/fifo_rvld valid the cycle after an accepted read.
//   FWFT=1 : first-word-fall-through. The head word sits in an output register
//            fed by a two-stage prefetch (RAM read register + head register).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   fifo_clr                 synchronous flush (drops contents, clears errors)
//   fifo_wen / fifo_wdat     write request / data
//   fifo_ren                 read request (FWFT: pop head)
//   fifo_rdat / fifo_rvld    read data / valid
//   fifo_ae_thr / fifo_af_thr  runtime almost-empty / almost-full thresholds
//   fifo_empty, fifo_full, fifo_aempty, fifo_afull  registered status flags
//   fifo_wcnt / fifo_rcnt    occupancy / free space
//   fifo_wr_full_err, fifo_rd_empty_err  one-cycle rejection pulses
//   fifo_err_sts             sticky {rd_empty, wr_full}
module sdp_sync_fifo_v2 #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_ADDR  = 4,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_clr,
    input  logic                  fifo_wen,
    input  logic [FIFO_WIDTH-1:0] fifo_wdat,
    input  logic                  fifo_ren,
    output logic [FIFO_WIDTH-1:0] fifo_rdat,
    output logic                  fifo_rvld,
    input  logic [FIFO_ADDR:0]    fifo_ae_thr,
    input  logic [FIFO_ADDR:0]    fifo_af_thr,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  fifo_aempty,
    output logic                  fifo_afull,
    output logic [FIFO_ADDR:0]    fifo_wcnt,
    output logic [FIFO_ADDR:0]    fifo_rcnt,
    output logic                  fifo_wr_full_err,
    output logic                  fifo_rd_empty_err,
    output logic [1:0]            fifo_err_sts
);

    localparam int              FIFO_DEPTH = 1 << FIFO_ADDR;
    localparam int              CW         = FIFO_ADDR + 1;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
    localparam int              STAGES     = 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_ADDR-1:0]  wptr, rptr;
    // Words written into the RAM but not yet read out of it. In FWFT mode
    // this differs from fifo_wcnt by the words sitting in the prefetch stages.
    logic [CW-1:0]         ram_cnt, ram_cnt_nxt;
    logic [FIFO_WIDTH-1:0] ram_q;
    // FWFT prefetch valids: [0] RAM read register, [1] head (output) register
    logic [STAGES:0]       vld_pipe, vld_nxt;

    logic          wr_acc, rd_acc, wr_err_nxt, rd_err_nxt;
    logic          head_ld, ram_rd, empty_nxt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        wr_acc     = fifo_wen && !fifo_full  && !fifo_clr;
        rd_acc     = fifo_ren && !fifo_empty && !fifo_clr;
        wr_err_nxt = fifo_wen &&  fifo_full  && !fifo_clr;
        rd_err_nxt = fifo_ren &&  fifo_empty && !fifo_clr;
        cnt_nxt    = fifo_wcnt + CW'(wr_acc) - CW'(rd_acc);
        head_ld    = 1'b0;
        ram_rd     = rd_acc;
        vld_nxt    = '0;
        if (FWFT) begin
            // Head refills from the RAM register when empty or being popped;
            // the RAM register refills whenever it is free or moving on.
            // Both hops can happen in one cycle, which sustains one pop/cycle.
            head_ld    = vld_pipe[0] && (!vld_pipe[1] || rd_acc);
            ram_rd     = (ram_cnt != '0) && (!vld_pipe[0] || head_ld) && !fifo_clr;
            vld_nxt[0] = ram_rd  || (vld_pipe[0] && !head_ld);
            vld_nxt[1] = head_ld || (vld_pipe[1] && !rd_acc);
        end
        ram_cnt_nxt = ram_cnt + CW'(wr_acc) - CW'(ram_rd);
        // In FWFT the FIFO only looks non-empty once a word reaches the head
        empty_nxt   = FWFT ? !vld_nxt[1] : (cnt_nxt == '0);
    end

    // RAM write port: no reset, contents are don't-care after rst/flush
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= fifo_wdat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr              <= '0;
            rptr              <= '0;
            ram_cnt           <= '0;
            ram_q             <= '0;
            vld_pipe          <= '0;
            fifo_wcnt         <= '0;
            fifo_rcnt         <= DEPTH_C;
            fifo_empty        <= 1'b1;
            fifo_aempty       <= 1'b1;
            fifo_full         <= 1'b0;
            fifo_afull        <= 1'b0;
            fifo_rdat         <= '0;
            fifo_rvld         <= 1'b0;
            fifo_wr_full_err  <= 1'b0;
            fifo_rd_empty_err <= 1'b0;
            fifo_err_sts      <= '0;
        end else if (fifo_clr) begin
            // fifo_rdat deliberately keeps its last value
            wptr              <= '0;
            rptr              <= '0;
            ram_cnt           <= '0;
            vld_pipe          <= '0;
            fifo_wcnt         <= '0;
            fifo_rcnt         <= DEPTH_C;
            fifo_empty        <= 1'b1;
            fifo_aempty       <= 1'b1;
            fifo_full         <= 1'b0;
            fifo_afull        <= 1'b0;
            fifo_rvld         <= 1'b0;
            fifo_wr_full_err  <= 1'b0;
            fifo_rd_empty_err <= 1'b0;
            fifo_err_sts      <= '0;
        end else begin
            wptr              <= wptr + FIFO_ADDR'(wr_acc);
            rptr              <= rptr + FIFO_ADDR'(ram_rd);
            ram_cnt           <= ram_cnt_nxt;
            vld_pipe          <= vld_nxt;
            fifo_wcnt         <= cnt_nxt;
            fifo_rcnt         <= DEPTH_C - cnt_nxt;
            fifo_empty        <= empty_nxt;
            fifo_full         <= (cnt_nxt == DEPTH_C);
            fifo_aempty       <= (cnt_nxt <= fifo_ae_thr);
            fifo_afull        <= (cnt_nxt >= fifo_af_thr);
            fifo_wr_full_err  <= wr_err_nxt;
            fifo_rd_empty_err <= rd_err_nxt;
            fifo_err_sts      <= fifo_err_sts | {rd_err_nxt, wr_err_nxt};
            if (FWFT) begin
                if (ram_rd)  ram_q     <= mem[rptr];
                if (head_ld) fifo_rdat <= ram_q;
                fifo_rvld <= vld_nxt[1];
            end else begin
                if (rd_acc)  fifo_rdat <= mem[rptr];
                fifo_rvld <= rd_acc;
            end
        end
    end

endmodule

// File: tb/tb_sdp_sync_fifo_v2.sv
// Bench for sdp_sync_fifo_v2: one standard-mode and one FWFT instance.
// Occupancy/error model plus a data scoreboard for each, a vector table for
// the full/threshold corner region, and hand sequences for flush and reset.
module tb_sdp_sync_fifo_v2;

    localparam int W = 32;
    localparam int A = 4;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // standard-mode instance
    logic         s_clr, s_wen, s_ren;
    logic [W-1:0] s_wdat, s_rdat;
    logic         s_rvld, s_empty, s_full, s_aempty, s_afull, s_werr, s_rerr;
    logic [A:0]   s_ae, s_af, s_wcnt, s_rcnt;
    logic [1:0]   s_sts;

    // FWFT instance
    logic         f_clr, f_wen, f_ren;
    logic [W-1:0] f_wdat, f_rdat;
    logic         f_rvld, f_empty, f_full, f_aempty, f_afull, f_werr, f_rerr;
    logic [A:0]   f_ae, f_af, f_wcnt, f_rcnt;
    logic [1:0]   f_sts;

    sdp_sync_fifo_v2 #(.FIFO_WIDTH(W), .FIFO_ADDR(A), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(rst), .fifo_clr(s_clr), .fifo_wen(s_wen), .fifo_wdat(s_wdat),
        .fifo_ren(s_ren), .fifo_rdat(s_rdat), .fifo_rvld(s_rvld),
        .fifo_ae_thr(s_ae), .fifo_af_thr(s_af), .fifo_empty(s_empty), .fifo_full(s_full),
        .fifo_aempty(s_aempty), .fifo_afull(s_afull), .fifo_wcnt(s_wcnt), .fifo_rcnt(s_rcnt),
        .fifo_wr_full_err(s_werr), .fifo_rd_empty_err(s_rerr), .fifo_err_sts(s_sts));

    sdp_sync_fifo_v2 #(.FIFO_WIDTH(W), .FIFO_ADDR(A), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .fifo_clr(f_clr), .fifo_wen(f_wen), .fifo_wdat(f_wdat),
        .fifo_ren(f_ren), .fifo_rdat(f_rdat), .fifo_rvld(f_rvld),
        .fifo_ae_thr(f_ae), .fifo_af_thr(f_af), .fifo_empty(f_empty), .fifo_full(f_full),
        .fifo_aempty(f_aempty), .fifo_afull(f_afull), .fifo_wcnt(f_wcnt), .fifo_rcnt(f_rcnt),
        .fifo_wr_full_err(f_werr), .fifo_rd_empty_err(f_rerr), .fifo_err_sts(f_sts));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- standard-mode model ----------------
    int           m_cnt;
    logic [1:0]   m_sts;
    logic [W-1:0] m_last;
    logic [W-1:0] s_wval;
    logic [W-1:0] sq[$];

    task automatic s_model_reset();
        m_cnt  = 0;
        m_sts  = 2'b00;
        m_last = '0;
        sq.delete();
    endtask

    task automatic s_cyc(input logic wen, input logic ren, input logic clr);
        logic wacc, racc, exp_we, exp_re;
        logic [W-1:0] exp_d;
        wacc   = wen && !clr && (m_cnt < D);
        racc   = ren && !clr && (m_cnt > 0);
        exp_we = wen && !clr && (m_cnt == D);
        exp_re = ren && !clr && (m_cnt == 0);
        if (wacc) sq.push_back(s_wval);
        s_wen = wen; s_ren = ren; s_clr = clr; s_wdat = s_wval;
        if (wen) s_wval++;
        if (clr) begin
            m_cnt = 0;
            m_sts = 2'b00;
            sq.delete();
        end else begin
            m_cnt = m_cnt + int'(wacc) - int'(racc);
            m_sts = m_sts | {exp_re, exp_we};
        end
        @(posedge clk); #1;
        s_wen = 1'b0; s_ren = 1'b0; s_clr = 1'b0;
        chk("s_rvld", {63'd0, s_rvld}, {63'd0, racc});
        if (racc) begin
            if (sq.size() == 0) begin
                chk("s_sb_underrun", 64'd1, 64'd0);
            end else begin
                exp_d  = sq.pop_front();
                m_last = exp_d;
            end
        end
        chk("s_rdat", 64'(s_rdat), 64'(m_last));
        chk("s_wcnt", 64'(s_wcnt), 64'(m_cnt));
        chk("s_rcnt", 64'(s_rcnt), 64'(D - m_cnt));
        chk("s_empty", {63'd0, s_empty}, {63'd0, m_cnt == 0});
        chk("s_full", {63'd0, s_full}, {63'd0, m_cnt == D});
        chk("s_aempty", {63'd0, s_aempty}, {63'd0, clr ? 1'b1 : (m_cnt <= int'(s_ae))});
        chk("s_afull", {63'd0, s_afull}, {63'd0, clr ? 1'b0 : (m_cnt >= int'(s_af))});
        chk("s_werr", {63'd0, s_werr}, {63'd0, exp_we});
        chk("s_rerr", {63'd0, s_rerr}, {63'd0, exp_re});
        chk("s_sts", 64'(s_sts), 64'(m_sts));
    endtask

    // ---------------- FWFT model ----------------
    int           f_cnt;
    logic [W-1:0] f_wval;
    logic [W-1:0] fq[$];

    task automatic f_cyc(input logic wen, input logic ren);
        logic wacc, racc;
        logic [W-1:0] exp_d;
        racc = ren && !f_empty;
        wacc = wen && (f_cnt < D);
        if (racc) begin
            if (fq.size() == 0) begin
                chk("f_sb_underrun", 64'd1, 64'd0);
            end else begin
                exp_d = fq.pop_front();
                chk("f_head", 64'(f_rdat), 64'(exp_d));
                chk("f_rvld", {63'd0, f_rvld}, 64'd1);
            end
        end
        if (wacc) fq.push_back(f_wval);
        f_wen = wen; f_ren = ren; f_wdat = f_wval;
        if (wen) f_wval++;
        f_cnt = f_cnt + int'(wacc) - int'(racc);
        @(posedge clk); #1;
        f_wen = 1'b0; f_ren = 1'b0;
        chk("f_wcnt", 64'(f_wcnt), 64'(f_cnt));
        chk("f_rcnt", 64'(f_rcnt), 64'(D - f_cnt));
        chk("f_full", {63'd0, f_full}, {63'd0, f_cnt == D});
    endtask

    // ---------------- vector table for the full/threshold region ----------------
    typedef struct {
        logic       wen, ren, clr;
        logic [A:0] ae, af;
        logic [A:0] wcnt;
        logic       full, empty, aempty, afull, werr, rerr;
        logic [1:0] sts;
    } vec_t;

    vec_t vecs[8];

    logic [W-1:0] held;

    initial begin
        // starts at occupancy 16 with ae=2, af=14
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd2, 5'd14, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 5'd2, 5'd14, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd2, 5'd14, 5'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 5'd2, 5'd14, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd2, 5'd14, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 5'd2, 5'd14, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 5'd2, 5'd10, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 5'd2, 5'd14, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};

        rst = 1'b1;
        s_clr = 1'b0; s_wen = 1'b0; s_ren = 1'b0; s_wdat = '0; s_ae = 5'd2; s_af = 5'd14;
        f_clr = 1'b0; f_wen = 1'b0; f_ren = 1'b0; f_wdat = '0; f_ae = 5'd2; f_af = 5'd14;
        s_wval = 32'h0;
        f_wval = 32'hA000_0000;
        f_cnt  = 0;
        s_model_reset();

        // reset values, visible without any clock edge
        #1;
        chk("rst_empty", {63'd0, s_empty}, 64'd1);
        chk("rst_aempty", {63'd0, s_aempty}, 64'd1);
        chk("rst_full", {63'd0, s_full}, 64'd0);
        chk("rst_afull", {63'd0, s_afull}, 64'd0);
        chk("rst_wcnt", 64'(s_wcnt), 64'd0);
        chk("rst_rcnt", 64'(s_rcnt), 64'd16);
        chk("rst_rdat", 64'(s_rdat), 64'd0);
        chk("rst_rvld", {63'd0, s_rvld}, 64'd0);
        chk("rst_errs", {62'd0, s_werr, s_rerr}, 64'd0);
        chk("rst_sts", 64'(s_sts), 64'd0);
        chk("rst_f_empty", {63'd0, f_empty}, 64'd1);
        chk("rst_f_rcnt", 64'(f_rcnt), 64'd16);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // fill 0x0..0xF
        for (int i = 0; i < D; i++) s_cyc(1'b1, 1'b0, 1'b0);
        chk("fill_full", {63'd0, s_full}, 64'd1);
        chk("fill_wcnt", 64'(s_wcnt), 64'd16);
        chk("fill_rcnt", 64'(s_rcnt), 64'd0);

        // overflow, simultaneous at full, threshold change
        for (int v = 0; v < 8; v++) begin
            s_ae = vecs[v].ae;
            s_af = vecs[v].af;
            s_cyc(vecs[v].wen, vecs[v].ren, vecs[v].clr);
            chk($sformatf("vec%0d_wcnt", v), 64'(s_wcnt), 64'(vecs[v].wcnt));
            chk($sformatf("vec%0d_flags", v),
                {58'd0, s_full, s_empty, s_aempty, s_afull, s_werr, s_rerr},
                {58'd0, vecs[v].full, vecs[v].empty, vecs[v].aempty, vecs[v].afull,
                 vecs[v].werr, vecs[v].rerr});
            chk($sformatf("vec%0d_sts", v), 64'(s_sts), 64'(vecs[v].sts));
        end

        // drain the remaining 12; last word out is 0xF
        for (int i = 0; i < 12; i++) s_cyc(1'b0, 1'b1, 1'b0);
        chk("drain_last", 64'(s_rdat), 64'hF);
        chk("drain_empty", {63'd0, s_empty}, 64'd1);

        // underflow: both sticky bits now set
        s_cyc(1'b0, 1'b1, 1'b0);
        chk("udf_pulse", {63'd0, s_rerr}, 64'd1);
        chk("udf_sts", 64'(s_sts), 64'd3);
        s_cyc(1'b0, 1'b0, 1'b1);
        chk("clr_sts", 64'(s_sts), 64'd0);

        // wen+ren at empty: write taken, read rejected
        s_cyc(1'b1, 1'b1, 1'b0);
        chk("emp_wr_rd_wcnt", 64'(s_wcnt), 64'd1);
        chk("emp_wr_rd_err", {63'd0, s_rerr}, 64'd1);

        // occupancy 5, 20 cycles of wen+ren across pointer wrap
        for (int i = 0; i < 4; i++) s_cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            s_cyc(1'b1, 1'b1, 1'b0);
            chk("steady5", 64'(s_wcnt), 64'd5);
        end

        // flush at occupancy 9 with wen/ren asserted; rdat holds
        for (int i = 0; i < 4; i++) s_cyc(1'b1, 1'b0, 1'b0);
        chk("pre_flush_wcnt", 64'(s_wcnt), 64'd9);
        held = s_rdat;
        s_cyc(1'b1, 1'b1, 1'b1);
        chk("flush_wcnt", 64'(s_wcnt), 64'd0);
        chk("flush_empty", {63'd0, s_empty}, 64'd1);
        chk("flush_rdat_hold", 64'(s_rdat), 64'(held));
        chk("flush_no_err", {62'd0, s_werr, s_rerr}, 64'd0);

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) s_cyc(1'b1, 1'b0, 1'b0);
        s_wen = 1'b1; s_wdat = s_wval;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_wcnt", 64'(s_wcnt), 64'd0);
        chk("arst_rcnt", 64'(s_rcnt), 64'd16);
        chk("arst_flags", {60'd0, s_empty, s_aempty, s_full, s_afull}, 64'b1100);
        chk("arst_rdat", {31'd0, s_rvld, s_rdat}, 64'd0);
        chk("arst_err", {60'd0, s_werr, s_rerr, s_sts}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        s_wen = 1'b0;
        s_model_reset();
        @(posedge clk); #1;
        chk("arst_rel_wcnt", 64'(s_wcnt), 64'd0);
        chk("arst_rel_err", {60'd0, s_werr, s_rerr, s_sts}, 64'd0);
        s_cyc(1'b1, 1'b0, 1'b0);
        s_cyc(1'b0, 1'b1, 1'b0);

        // ---------------- FWFT ----------------
        // both instances were reset above; FWFT model starts empty
        f_cnt = 0;
        fq.delete();
        f_cyc(1'b1, 1'b0);                // edge k
        chk("fwft_k_empty", {63'd0, f_empty}, 64'd1);
        chk("fwft_k_rvld", {63'd0, f_rvld}, 64'd0);
        f_cyc(1'b0, 1'b0);                // edge k+1
        chk("fwft_k1_empty", {63'd0, f_empty}, 64'd1);
        f_cyc(1'b0, 1'b0);                // edge k+2
        chk("fwft_k2_empty", {63'd0, f_empty}, 64'd0);
        chk("fwft_k2_rvld", {63'd0, f_rvld}, 64'd1);
        chk("fwft_k2_rdat", 64'(f_rdat), 64'hA000_0000);

        for (int i = 0; i < 15; i++) f_cyc(1'b1, 1'b0);
        chk("fwft_full", {63'd0, f_full}, 64'd1);
        chk("fwft_full_wcnt", 64'(f_wcnt), 64'd16);
        f_cyc(1'b1, 1'b0);
        chk("fwft_ovf_err", {63'd0, f_werr}, 64'd1);
        chk("fwft_ovf_sts", 64'(f_sts), 64'd1);

        // 16 back-to-back pops: a word must be presented every cycle
        for (int i = 0; i < D; i++) begin
            chk("fwft_b2b_avail", {63'd0, f_empty}, 64'd0);
            f_cyc(1'b0, 1'b1);
        end
        chk("fwft_drain_empty", {63'd0, f_empty}, 64'd1);
        chk("fwft_drain_wcnt", 64'(f_wcnt), 64'd0);
        chk("fwft_drain_rvld", {63'd0, f_rvld}, 64'd0);

        // steady wen+ren at occupancy 3
        for (int i = 0; i < 3; i++) f_cyc(1'b1, 1'b0);
        f_cyc(1'b0, 1'b0);
        f_cyc(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("fwft_steady_avail", {63'd0, f_empty}, 64'd0);
            f_cyc(1'b1, 1'b1);
        end
        chk("fwft_steady_wcnt", 64'(f_wcnt), 64'd3);

        // FWFT flush: head register keeps its value, status clears
        held = f_rdat;
        f_clr = 1'b1; f_wen = 1'b1; f_ren = 1'b1;
        @(posedge clk); #1;
        f_clr = 1'b0; f_wen = 1'b0; f_ren = 1'b0;
        f_cnt = 0;
        fq.delete();
        chk("fwft_flush_wcnt", 64'(f_wcnt), 64'd0);
        chk("fwft_flush_empty", {63'd0, f_empty}, 64'd1);
        chk("fwft_flush_rvld", {63'd0, f_rvld}, 64'd0);
        chk("fwft_flush_rdat", 64'(f_rdat), 64'(held));
        chk("fwft_flush_sts", {60'd0, f_werr, f_rerr, f_sts}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
